multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/rv32_ctrl_pkg.sv | 79 +++++++
 rtl/branch_resolve.sv | 22 ++
 rtl/multicycle_controller.sv | 179 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// rtl/rv32_ctrl_pkg.sv - shared types, opcodes and select encodings for the multicycle controller
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_LOAD_IR = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM_RD  = 3'd4,
    ST_MEM_WR  = 3'd5,
    ST_WB      = 3'd6,
    ST_TRAP    = 3'd7
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic PC_SRC_PC4   = 1'b0;
  localparam logic PC_SRC_ALU   = 1'b1;
  localparam logic ADDR_SRC_PC  = 1'b0;
  localparam logic ADDR_SRC_ALU = 1'b1;

  localparam logic [1:0] ALU_SRC_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'd1;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_MODE_ADD    = 2'd0;
  localparam logic [1:0] ALU_MODE_OP     = 2'd1;
  localparam logic [1:0] ALU_MODE_BRANCH = 2'd2;

  localparam logic [1:0] RES_IMM = 2'd0;
  localparam logic [1:0] RES_ALU = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_MEM = 2'd3;

  typedef enum logic [3:0] {
    CL_ALU_R,
    CL_ALU_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC,
    CL_ILLEGAL
  } iclass_t;

  // Map a raw opcode onto the instruction class that drives sequencing.
  function automatic iclass_t classify(input logic [6:0] op);
    case (op)
      OP_REG:    classify = CL_ALU_R;
      OP_IMM:    classify = CL_ALU_I;
      OP_LOAD:   classify = CL_LOAD;
      OP_STORE:  classify = CL_STORE;
      OP_BRANCH: classify = CL_BRANCH;
      OP_JAL:    classify = CL_JAL;
      OP_JALR:   classify = CL_JALR;
      OP_LUI:    classify = CL_LUI;
      OP_AUIPC:  classify = CL_AUIPC;
      default:   classify = CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - combinational branch-taken evaluation from funct3 and ALU flags
module branch_resolve
  import rv32_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero_flag,
  input  logic       alu_lt,
  output logic       taken
);

  // Equality branches use the zero flag, ordered compares use the SLT result; 010/011 never branch.
  always_comb begin
    case (funct3)
      F3_BEQ:           taken = zero_flag;
      F3_BNE:           taken = !zero_flag;
      F3_BLT, F3_BLTU:  taken = alu_lt;
      F3_BGE, F3_BGEU:  taken = !alu_lt;
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32 control FSM; ILLEGAL_OP_TRAP_EN selects trap vs NOP on illegal opcodes
module multicycle_controller
  import rv32_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero_flag,
  input  logic        alu_lt,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        addr_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_mode,
  output logic [1:0]  result_src,
  output logic        instr_done,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  state_t  state_q;
  state_t  state_d;
  iclass_t iclass;
  logic    taken;

  assign iclass = classify(opcode);
  assign state  = state_q;

  branch_resolve u_branch_resolve (
    .funct3    (funct3),
    .zero_flag (zero_flag),
    .alu_lt    (alu_lt),
    .taken     (taken)
  );

  // State register; reset forces FETCH regardless of where the instruction was.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next-state sequencing by instruction class.
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:   state_d = ST_LOAD_IR;
      ST_LOAD_IR: state_d = ST_DECODE;
      ST_DECODE: begin
        case (iclass)
          CL_LUI, CL_AUIPC: state_d = ST_WB;
`ifdef ILLEGAL_OP_TRAP_EN
          CL_ILLEGAL:       state_d = ST_TRAP;
`else
          CL_ILLEGAL:       state_d = ST_FETCH;
`endif
          default:          state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (iclass)
          CL_LOAD:   state_d = ST_MEM_RD;
          CL_STORE:  state_d = ST_MEM_WR;
          CL_BRANCH: state_d = ST_FETCH;
          default:   state_d = ST_WB;
        endcase
      end
      ST_MEM_RD:  state_d = ST_WB;
      ST_MEM_WR:  state_d = ST_FETCH;
      ST_WB:      state_d = ST_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      ST_TRAP:    state_d = ST_TRAP;
`endif
      default:    state_d = ST_FETCH;
    endcase
  end

  // Per-state strobes and selects; everything is held low while reset is asserted.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_PC4;
    addr_src   = ADDR_SRC_PC;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALU_SRC_B_RS2;
    alu_mode   = ALU_MODE_ADD;
    result_src = RES_IMM;
    instr_done = 1'b0;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          addr_src = ADDR_SRC_PC;
        end
        ST_LOAD_IR: ir_write = 1'b1;
        ST_DECODE: begin
`ifndef ILLEGAL_OP_TRAP_EN
          if (iclass == CL_ILLEGAL) begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_PC4;
            instr_done = 1'b1;
          end
`endif
        end
        ST_EXEC: begin
          case (iclass)
            CL_ALU_R: begin
              alu_src_a = 1'b1;
              alu_src_b = ALU_SRC_B_RS2;
              alu_mode  = ALU_MODE_OP;
            end
            CL_ALU_I: begin
              alu_src_a = 1'b1;
              alu_src_b = ALU_SRC_B_IMM;
              alu_mode  = ALU_MODE_OP;
            end
            CL_LOAD, CL_STORE, CL_JALR: begin
              alu_src_a = 1'b1;
              alu_src_b = ALU_SRC_B_IMM;
              alu_mode  = ALU_MODE_ADD;
            end
            CL_BRANCH: begin
              alu_src_a  = 1'b1;
              alu_src_b  = ALU_SRC_B_RS2;
              alu_mode   = ALU_MODE_BRANCH;
              pc_write   = 1'b1;
              pc_src     = taken ? PC_SRC_ALU : PC_SRC_PC4;
              instr_done = 1'b1;
            end
            CL_JAL: begin
              alu_src_a = 1'b0;
              alu_src_b = ALU_SRC_B_IMM;
              alu_mode  = ALU_MODE_ADD;
            end
            default: ;
          endcase
        end
        ST_MEM_RD: begin
          mem_read = 1'b1;
          addr_src = ADDR_SRC_ALU;
        end
        ST_MEM_WR: begin
          mem_write  = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_SRC_PC4;
          instr_done = 1'b1;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          case (iclass)
            CL_LUI:          result_src = RES_IMM;
            CL_LOAD:         result_src = RES_MEM;
            CL_JAL, CL_JALR: result_src = RES_PC4;
            default:         result_src = RES_ALU;
          endcase
          pc_src = (iclass == CL_JAL || iclass == CL_JALR) ? PC_SRC_ALU : PC_SRC_PC4;
        end
        default: ;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!reset)          instret <= 32'd0;
    else if (instr_done) instret <= instret + 32'd1;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_LOAD_IR = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_MEM_RD  = 3'd4;
  localparam logic [2:0] S_MEM_WR  = 3'd5;
  localparam logic [2:0] S_WB      = 3'd6;
  localparam logic [2:0] S_TRAP    = 3'd7;

  // ctl = {ir_write, pc_write, pc_src, addr_src, mem_read, mem_write, reg_write,
  //        alu_src_a, alu_src_b[1:0], alu_mode[1:0], result_src[1:0], instr_done}
  localparam logic [14:0] C_IDLE      = 15'h0000;
  localparam logic [14:0] C_FETCH     = 15'h0400;
  localparam logic [14:0] C_LOAD_IR   = 15'h4000;
  localparam logic [14:0] C_EXEC_IALU = 15'h00A8;
  localparam logic [14:0] C_EXEC_LS   = 15'h00A0;
  localparam logic [14:0] C_EXEC_JAL  = 15'h0020;
  localparam logic [14:0] C_BR_TAKEN  = 15'h3091;
  localparam logic [14:0] C_BR_NOT    = 15'h2091;
  localparam logic [14:0] C_MEM_RD    = 15'h0C00;
  localparam logic [14:0] C_MEM_WR    = 15'h2201;
  localparam logic [14:0] C_WB_ALU    = 15'h2103;
  localparam logic [14:0] C_WB_MEM    = 15'h2107;
  localparam logic [14:0] C_WB_JAL    = 15'h3105;
  localparam logic [14:0] C_WB_LUI    = 15'h2101;
  localparam logic [14:0] C_NOP_DEC   = 15'h2001;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero_flag;
  logic        alu_lt;
  logic        ir_write, pc_write, pc_src, addr_src, mem_read, mem_write, reg_write;
  logic        alu_src_a, instr_done;
  logic [1:0]  alu_src_b, alu_mode, result_src;
  logic [31:0] instret;
  logic [2:0]  state;
  logic [14:0] ctl;

  int vectors = 0;
  int miscompares = 0;

  assign ctl = {ir_write, pc_write, pc_src, addr_src, mem_read, mem_write, reg_write,
                alu_src_a, alu_src_b, alu_mode, result_src, instr_done};

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero_flag  (zero_flag),
    .alu_lt     (alu_lt),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .addr_src   (addr_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_mode   (alu_mode),
    .result_src (result_src),
    .instr_done (instr_done),
    .instret    (instret),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [14:0] c);
    @(posedge clk);
    #1;
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_ctl"}, 32'(ctl), 32'(c));
    chk({tag, "_rw_excl"}, 32'(mem_read & mem_write), 32'd0);
  endtask

  task automatic front(input string tag, input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
    step({tag, "_ldir"}, S_LOAD_IR, C_LOAD_IR);
    step({tag, "_dec"}, S_DECODE, C_IDLE);
  endtask

  initial begin
    reset = 1'b0;
    opcode = 7'd0;
    funct3 = 3'd0;
    zero_flag = 1'b0;
    alu_lt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(S_FETCH));
    chk("rst_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rst_instret", instret, 32'd0);
    reset = 1'b1;
    #1;
    chk("first_fetch", 32'(ctl), 32'(C_FETCH));

    // ADDI
    front("addi", 7'b0010011, 3'b000);
    step("addi_exec", S_EXEC, C_EXEC_IALU);
    step("addi_wb", S_WB, C_WB_ALU);
    chk("addi_instret_pre", instret, 32'd0);
    step("addi_end", S_FETCH, C_FETCH);
    chk("addi_instret", instret, 32'd1);

    // LW: six cycles
    front("lw", 7'b0000011, 3'b010);
    step("lw_exec", S_EXEC, C_EXEC_LS);
    step("lw_memrd", S_MEM_RD, C_MEM_RD);
    step("lw_wb", S_WB, C_WB_MEM);
    step("lw_end", S_FETCH, C_FETCH);
    chk("lw_instret", instret, 32'd2);

    // BEQ taken, then not taken
    zero_flag = 1'b1;
    front("beq_t", 7'b1100011, 3'b000);
    step("beq_t_exec", S_EXEC, C_BR_TAKEN);
    step("beq_t_end", S_FETCH, C_FETCH);
    zero_flag = 1'b0;
    front("beq_n", 7'b1100011, 3'b000);
    step("beq_n_exec", S_EXEC, C_BR_NOT);
    step("beq_n_end", S_FETCH, C_FETCH);
    chk("beq_instret", instret, 32'd4);

    // SW
    front("sw", 7'b0100011, 3'b010);
    step("sw_exec", S_EXEC, C_EXEC_LS);
    step("sw_memwr", S_MEM_WR, C_MEM_WR);
    step("sw_end", S_FETCH, C_FETCH);

    // JAL
    front("jal", 7'b1101111, 3'b000);
    step("jal_exec", S_EXEC, C_EXEC_JAL);
    step("jal_wb", S_WB, C_WB_JAL);
    step("jal_end", S_FETCH, C_FETCH);

    // LUI skips EXEC
    front("lui", 7'b0110111, 3'b000);
    step("lui_wb", S_WB, C_WB_LUI);
    step("lui_end", S_FETCH, C_FETCH);

    // BLT taken on alu_lt; funct3 010 never taken even with both flags high
    alu_lt = 1'b1;
    front("blt", 7'b1100011, 3'b100);
    step("blt_exec", S_EXEC, C_BR_TAKEN);
    step("blt_end", S_FETCH, C_FETCH);
    zero_flag = 1'b1;
    front("b010", 7'b1100011, 3'b010);
    step("b010_exec", S_EXEC, C_BR_NOT);
    step("b010_end", S_FETCH, C_FETCH);
    zero_flag = 1'b0;
    alu_lt = 1'b0;
    chk("mix_instret", instret, 32'd9);

    // Reset in MEM_WR of a store
    front("swr", 7'b0100011, 3'b010);
    step("swr_exec", S_EXEC, C_EXEC_LS);
    step("swr_memwr", S_MEM_WR, C_MEM_WR);
    reset = 1'b0;
    step("swr_rst", S_FETCH, C_IDLE);
    chk("swr_rst_instret", instret, 32'd0);
    reset = 1'b1;
    #1;
    chk("swr_refetch", 32'(ctl), 32'(C_FETCH));

    // Illegal opcode 0000000
    opcode = 7'b0000000;
    funct3 = 3'b000;
    step("ill_ldir", S_LOAD_IR, C_LOAD_IR);
`ifdef ILLEGAL_OP_TRAP_EN
    step("ill_dec", S_DECODE, C_IDLE);
    for (int i = 0; i < 10; i++) step("ill_trap", S_TRAP, C_IDLE);
    chk("ill_instret", instret, 32'd0);
`else
    step("ill_dec", S_DECODE, C_NOP_DEC);
    step("ill_end", S_FETCH, C_FETCH);
    chk("ill_instret", instret, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
